// File: rtl/div_if.sv
// Divide unit request/response bundle: start/op/operands/flush in,
// busy/result_valid/result out. master = pipeline side, slave = div unit.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       funct3;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             flush;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3, data1, data2, flush,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, funct3, data1, data2, flush,
    output busy, result_valid, result
  );
endinterface

// File: rtl/div_sequencer.sv
// RV32M multi-cycle divider: IDLE->PREP->ITER(x32)->FIX->DONE, restoring
// division on magnitudes, sign fix-up, FLUSH abort, one-cycle RESULT_VALID.
// Ports: clk_i, rst_ni (async active-low), bus (div_if.slave).
// Option: DIV_SEQUENCER_EARLY_OUT_EN resolves /0 and signed overflow in PREP.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  div_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic             sgn;
  logic             na;
  logic             nb;
  logic [WIDTH:0]   shift_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // op_q[0]=1 marks the unsigned variants
  assign sgn     = ~op_q[0];
  assign na      = sgn & a_q[WIDTH-1];
  assign nb      = sgn & b_q[WIDTH-1];
  // a_q shifts dividend bits out the top and quotient bits in the bottom
  assign shift_w = {rem_q, a_q[WIDTH-1]};
  assign diff_w  = shift_w - {1'b0, b_q};
  assign q_fix   = negq_q ? (~a_q + 1'b1) : a_q;
  assign r_fix   = negr_q ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.data1;
          b_d     = bus.data2;
          op_d    = bus.funct3;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        a_d     = na ? (~a_q + 1'b1) : a_q;
        b_d     = nb ? (~b_q + 1'b1) : b_q;
        negq_d  = (na ^ nb) & (b_q != '0);
        negr_d  = na;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_ITER;
`ifdef DIV_SEQUENCER_EARLY_OUT_EN
        if (b_q == '0) begin
          res_d   = op_q[1] ? a_q : '1;
          state_d = S_DONE;
        end else if (sgn && a_q == MIN_NEG && b_q == '1) begin
          res_d   = op_q[1] ? '0 : MIN_NEG;
          state_d = S_DONE;
        end
`endif
      end
      S_ITER: begin
        // borrow out (diff_w[WIDTH]) means the trial subtract failed
        if (!diff_w[WIDTH]) begin
          rem_d = diff_w[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shift_w[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(WIDTH-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_d   = op_q[1] ? r_fix : q_fix;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // flush wins over everything and leaves the visible result alone
    if (bus.flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign bus.busy = (state_q == S_PREP) ||
                    (state_q == S_ITER) ||
                    (state_q == S_FIX);
  assign bus.result_valid = (state_q == S_DONE);
  assign bus.result       = res_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: cycle-level reference model plus directed
// and randomized divide operations, flush and async reset.
module tb_div_sequencer;

  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  div_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0) return f[1] ? a : ONES;
    if (!f[0] && a == MINV && b == ONES) return f[1] ? 32'd0 : MINV;
    case (f)
      2'b00:   r = $signed(a) / $signed(b);
      2'b01:   r = a / b;
      2'b10:   r = $signed(a) % $signed(b);
      default: r = a % b;
    endcase
    return r;
  endfunction

  function automatic bit special(input logic [1:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef DIV_SEQUENCER_EARLY_OUT_EN
    return (b == 32'd0) || (!f[0] && a == MINV && b == ONES);
`else
    return 1'b0;
`endif
  endfunction

  // m_age: -1 idle, else cycles since the accepting edge; 34 = result cycle
  int          m_age  = -1;
  logic [31:0] m_res  = '0;
  logic [31:0] m_pend = '0;
  bit          m_sp   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= -1;
      m_res <= '0;
    end else if (m_age < 0) begin
      if (bus.start) begin
        m_age  <= 0;
        m_pend <= ref_res(bus.funct3, bus.data1, bus.data2);
        m_sp   <= special(bus.funct3, bus.data1, bus.data2);
      end
    end else if (bus.flush || m_age >= 34) begin
      m_age <= -1;
    end else if (m_age == 0 && m_sp) begin
      m_age <= 34;
      m_res <= m_pend;
    end else begin
      m_age <= m_age + 1;
      if (m_age + 1 == 34) m_res <= m_pend;
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {31'd0, bus.busy},
        {31'd0, (m_age >= 0 && m_age <= 33)});
    chk("cyc_valid", {31'd0, bus.result_valid}, {31'd0, (m_age == 34)});
    chk("cyc_result", bus.result, m_res);
  end

  task automatic run_op(input string nm, input logic [1:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int got;
    int lat;
    lat = special(f, a, b) ? 1 : 34;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.data1  = a;
    bus.data2  = b;
    @(posedge clk);
    got = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      bus.start  = (k == 20);
      bus.funct3 = 2'($urandom);
      bus.data1  = $urandom;
      bus.data2  = $urandom;
      if (bus.result_valid) begin
        got = k;
        break;
      end
    end
    if (got < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=none exp=valid", nm);
    end else begin
      chk({nm, "_lat"}, got, lat);
      chk({nm, "_res"}, bus.result, exp);
      // start during DONE must be ignored
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.data1  = '0;
    bus.data2  = '0;
    bus.flush  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;

    chk("model_div", ref_res(2'b00, 32'd20, 32'hFFFF_FFFD), 32'hFFFF_FFFA);
    chk("model_remu", ref_res(2'b11, 32'hFFFF_FFEC, 32'd3), 32'd2);

    run_op("div_ovf", 2'b00, MINV, ONES, MINV);
    run_op("rem_ovf", 2'b10, MINV, ONES, 32'd0);
    run_op("div_neg", 2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA);
    run_op("rem_neg", 2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
    run_op("remu", 2'b11, 32'hFFFF_FFEC, 32'd3, 32'd2);
    run_op("div_z", 2'b00, 32'd7, 32'd0, ONES);
    run_op("rem_z", 2'b10, 32'd7, 32'd0, 32'd7);

    // flush on the 10th ITER cycle
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 2'b00;
    bus.data1  = 32'd1000;
    bus.data2  = 32'd3;
    @(posedge clk);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("flush_result", bus.result, 32'd7);
    run_op("divu_post_flush", 2'b01, 32'd100, 32'd7, 32'd14);

    // async reset in the middle of ITER
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 2'b01;
    bus.data1  = 32'h0000_FFFF;
    bus.data2  = 32'd5;
    @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      bus.start = (k == 5);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_post_rst", 2'b01, 32'd9, 32'd3, 32'd3);

    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = MINV; b = ONES; end
        2: begin
          a = $urandom_range(0, 200);
          b = $urandom_range(1, 20);
        end
        3: b = $urandom_range(0, 1) ? 32'($urandom_range(1, 9)) :
                                      ONES - 32'($urandom_range(0, 8));
        default: ;
      endcase
      run_op("rand", f, a, b, ref_res(f, a, b));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; the block SHALL be built and verified at 32 only.
REQ-002 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  request a divide; SHALL be sampled only in IDLE.
REQ-005 FUNCT3  input  2  op select: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M funct3[1:0]).
REQ-006 DATA1  input  32  dividend.
REQ-007 DATA2  input  32  divisor.
REQ-008 FLUSH  input  1  synchronous abort from pipeline control.
REQ-009 BUSY  output  1  high while an operation occupies the unit; pipeline stall source.
REQ-010 RESULT_VALID  output  1  one-cycle pulse marking RESULT valid.
REQ-011 RESULT  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-012 States SHALL be IDLE, PREP, ITER, FIX and DONE.
REQ-013 IDLE + START=1 at an edge SHALL latch DATA1, DATA2 and FUNCT3 and enter PREP; later input changes SHALL be ignored.
REQ-014 PREP SHALL two's-complement (~x+1) each negative operand for signed ops (DIV, REM), pass operands unchanged for unsigned ops, clear the 5-bit iteration counter and enter ITER.
REQ-015 ITER SHALL run restoring division on the 32-bit magnitudes, one quotient bit per cycle MSB first, for exactly 32 cycles, then enter FIX.
REQ-016 FIX SHALL negate the quotient iff the op is signed, operand signs differ and divisor is nonzero.
REQ-017 FIX SHALL negate the remainder iff the op is signed and the dividend is negative.
REQ-018 FIX SHALL register the selected value into RESULT and enter DONE.
REQ-019 DONE SHALL drive RESULT_VALID=1 for exactly one cycle, then enter IDLE.
REQ-020 Latency: with START sampled at edge N, RESULT_VALID SHALL be high in the cycle after edge N+34.
REQ-021 BUSY SHALL be 1 in PREP, ITER and FIX, and 0 in IDLE and DONE.
REQ-022 START outside IDLE, including in DONE, SHALL be ignored.
REQ-023 Divide by zero SHALL yield quotient 0xFFFFFFFF and remainder equal to DATA1 for all four ops.
REQ-024 DIV/REM with 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0.
REQ-025 FLUSH=1 at an edge in any non-IDLE state SHALL force IDLE at that edge with no RESULT_VALID pulse.
REQ-026 FLUSH SHALL take priority over START and over completion; RESULT SHALL be unchanged by a flush.
REQ-027 RESULT SHALL hold its last value until the next DONE.

Reset
REQ-028 RESET_N=0 SHALL immediately force IDLE, BUSY=0, RESULT_VALID=0, RESULT=0, counter=0 and operand registers=0, independent of CLK.
REQ-029 Reset mid-operation SHALL abandon the operation with no RESULT_VALID pulse.
REQ-030 The first START after RESET_N rises SHALL behave as from power-up.

Configuration
REQ-031 Macro DIV_SEQUENCER_EARLY_OUT_EN: when defined, PREP SHALL detect divide-by-zero and signed overflow (REQ-023/024), load the special result and go directly to DONE, giving RESULT_VALID in the cycle after edge N+1.
REQ-032 When DIV_SEQUENCER_EARLY_OUT_EN is undefined, special cases SHALL take the full REQ-020 latency, with results still per REQ-023/024.

Verification
REQ-033 DIV 20 / 0xFFFFFFFD (-3) -> RESULT 0xFFFFFFFA; RESULT_VALID after edge N+34; BUSY high cycles N+1..N+33.
REQ-034 REM 0xFFFFFFEC (-20) / 3 -> 0xFFFFFFFE; REMU 0xFFFFFFEC / 3 -> 0x00000002.
REQ-035 DIV 7 / 0 -> 0xFFFFFFFF; REM 7 / 0 -> 7; with macro RESULT_VALID after edge N+1, without it after edge N+34.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-037 FLUSH on 10th ITER cycle -> IDLE next edge, no RESULT_VALID, RESULT unchanged; immediate new DIVU 100 / 7 -> 14.
REQ-038 RESET_N low mid-ITER -> all outputs 0 without a clock edge; START while BUSY ignored; post-reset DIVU 9 / 3 -> 3.
